// File: rtl/time_ctrl.sv
// Sequencer for the hh:mm:ss counter chain: 1 Hz prescaler, button sync, RUN/SET_MIN/SET_HR FSM.
// Optional 2 Hz blink strobe for the field being set is enabled with SIMPLE_CLOCK_BLINK_EN.
module time_ctrl #(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       max_s0,
  input  logic       max_s1,
  input  logic       max_m0,
  input  logic       max_m1,
  input  logic       max_h,
  output logic       ena_s0,
  output logic       ena_s1,
  output logic       ena_m0,
  output logic       ena_m1,
  output logic       ena_h,
  output logic [1:0] mode,
  output logic       tick,
  output logic       blink
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_HR  = 2'b10
  } mode_t;

  mode_t         state;
  mode_t         next_state;
  logic [2:0]    mode_sh;
  logic [2:0]    inc_sh;
  logic          mode_pulse;
  logic          inc_pulse;
  logic          inc_eff;
  logic          run_steady;
  logic [CW-1:0] cnt;
  logic          unused;

  // The hour counter wraps on its own; its max flag is not needed here.
  assign unused = max_h;

  // [0] metastable stage, [1] synchronized level, [2] previous level.
  // Reset to ones so a button held through reset produces no edge.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      mode_sh    <= '1;
      inc_sh     <= '1;
      mode_pulse <= 1'b0;
      inc_pulse  <= 1'b0;
    end else begin
      mode_sh    <= {mode_sh[1:0], btn_mode};
      inc_sh     <= {inc_sh[1:0], btn_inc};
      mode_pulse <= mode_sh[1] & ~mode_sh[2];
      inc_pulse  <= inc_sh[1] & ~inc_sh[2];
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (mode_pulse) next_state = SET_MIN;
      SET_MIN: if (mode_pulse) next_state = SET_HR;
      SET_HR:  if (mode_pulse) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  assign mode = state;

  // Prescaler only runs while RUN is both current and next mode, so it is
  // held at zero through SET_* and the first tick after returning is a full period away.
  assign run_steady = (state == RUN) && (next_state == RUN);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!run_steady) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // A mode change in the same cycle as an increment swallows the increment.
  assign inc_eff = inc_pulse & ~mode_pulse;

  always_comb begin
    ena_s0 = 1'b0;
    ena_s1 = 1'b0;
    ena_m0 = 1'b0;
    ena_m1 = 1'b0;
    ena_h  = 1'b0;
    case (state)
      RUN: begin
        ena_s0 = tick;
        ena_s1 = tick & max_s0;
        ena_m0 = tick & max_s0 & max_s1;
        ena_m1 = tick & max_s0 & max_s1 & max_m0;
        ena_h  = tick & max_s0 & max_s1 & max_m0 & max_m1;
      end
      SET_MIN: begin
        ena_m0 = inc_eff;
        ena_m1 = inc_eff & max_m0;
      end
      SET_HR: begin
        ena_h = inc_eff;
      end
      default: begin
        ena_s0 = 1'b0;
      end
    endcase
  end

`ifdef SIMPLE_CLOCK_BLINK_EN
  localparam int unsigned BP = TICK_DIV / 2;
  localparam logic [CW-1:0] BLAST = CW'(BP - 1);
  localparam logic [CW-1:0] BHALF = CW'(BP / 2);

  logic [CW-1:0] bcnt;

  // Restarting on any press keeps the edited field visible right after the press.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      bcnt <= '0;
    end else if (mode_pulse || inc_pulse) begin
      bcnt <= '0;
    end else if (bcnt == BLAST) begin
      bcnt <= '0;
    end else begin
      bcnt <= bcnt + CW'(1);
    end
  end

  assign blink = (state != RUN) && (bcnt >= BHALF);
`else
  assign blink = 1'b0;
`endif

endmodule
